// File: rtl/wf_slot_rr_arbiter.sv
// Round-robin grant arbiter over the wavefront slots feeding the issue stage.
// A single registered grant (id plus one-hot) is held until the consumer acks it.
// On an ack the priority pointer moves past the winner and the next grant is
// picked in the same cycle, so continuous acks give one grant per cycle.

// Enabled 6b-to-40b decoder, one compare per output bit.
module wf_dec6to40 #(
    parameter int N_OUT = 40,
    parameter int IN_W  = 6
) (
    input  logic             en,
    input  logic [IN_W-1:0]  sel,
    output logic [N_OUT-1:0] dout
);
    for (genvar g = 0; g < N_OUT; g++) begin : g_dec
        assign dout[g] = en && (sel == IN_W'(g));
    end
endmodule

module wf_slot_rr_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] req,
    input  logic              grant_ack,
    output logic              arb_valid,
    output logic [WFID_W-1:0] arb_wfid,
    output logic [NUM_WF-1:0] arb_onehot,
    output logic [WFID_W-1:0] prio_ptr
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic              arb_valid_q, arb_valid_d;
    logic [WFID_W-1:0] arb_wfid_q, arb_wfid_d;
    logic [WFID_W-1:0] prio_ptr_q, prio_ptr_d;

    logic [WFID_W-1:0] nxt_ptr;
    logic [WFID_W-1:0] pick_start;
    logic [NUM_WF-1:0] pick_vec;
    logic              pick_found;
    logic [WFID_W-1:0] pick_id;

    // One-hot grant comes straight from the registered id, gated by valid.
    wf_dec6to40 #(.N_OUT(NUM_WF), .IN_W(WFID_W)) u_dec (
        .en   (arb_valid_q),
        .sel  (arb_wfid_q),
        .dout (arb_onehot)
    );

    // Pointer one past the current winner, wrapping at the last slot (mod 40).
    assign nxt_ptr = (arb_wfid_q == WFID_W'(NUM_WF - 1)) ? '0 : arb_wfid_q + 1'b1;

    // In GRANT the pick serves the ack re-pick: search from past the winner with
    // the winner masked out. In IDLE the one-hot is zero, so req passes intact.
    assign pick_start = (state_q == GRANT) ? nxt_ptr : prio_ptr_q;
    assign pick_vec   = req & ~arb_onehot;

    // Rotating priority search over all slots starting at pick_start.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            idx = int'(pick_start) + i;
            if (idx >= NUM_WF) idx = idx - NUM_WF;
            if (!pick_found && pick_vec[idx]) begin
                pick_found = 1'b1;
                pick_id    = WFID_W'(idx);
            end
        end
    end

    // Next-state and next-output decisions for the grant FSM.
    always_comb begin
        state_d     = state_q;
        arb_valid_d = arb_valid_q;
        arb_wfid_d  = arb_wfid_q;
        prio_ptr_d  = prio_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    arb_wfid_d  = pick_id;
                    arb_valid_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    // Ack wins even if the granted req dropped this cycle.
                    prio_ptr_d = nxt_ptr;
                    if (pick_found) begin
                        arb_wfid_d = pick_id;
                    end else begin
                        arb_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (!req[arb_wfid_q]) begin
                    // Cancel: release without re-pick, pointer untouched.
                    arb_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                arb_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            arb_valid_q <= 1'b0;
            arb_wfid_q  <= '0;
            prio_ptr_q  <= '0;
        end else begin
            state_q     <= state_d;
            arb_valid_q <= arb_valid_d;
            arb_wfid_q  <= arb_wfid_d;
            prio_ptr_q  <= prio_ptr_d;
        end
    end

    assign arb_valid = arb_valid_q;
    assign arb_wfid  = arb_wfid_q;
    assign prio_ptr  = prio_ptr_q;
endmodule
